// File: rtl/vx_fill_assembler_pkg.sv
// ---------------------------------------------------------------------------
// vx_fill_assembler_pkg
//
// Shared cache-fill definitions used by the fill assembler and its bench:
//   - default line geometry (line size, memory beat width, line address width)
//   - the assembler state encoding (IDLE / COLLECT / FULL)
//   - helpers that derive the number of memory beats per line and the
//     width of the beat counter from the geometry
// ---------------------------------------------------------------------------
package vx_fill_assembler_pkg;

  // Default line geometry.
  localparam int DEFAULT_CACHE_LINE_SIZE = 64;   // bytes per line
  localparam int DEFAULT_MEM_DATA_WIDTH  = 128;  // bits per response beat
  localparam int DEFAULT_LINE_ADDR_WIDTH = 26;   // line address bits

  // Assembler state encoding.
  //   IDLE    : no partial line held, waiting for beat 0
  //   COLLECT : beats 1..BEATS-1 of the current line are being gathered
  //   FULL    : the whole line is held and offered on the fill port
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } fill_state_e;

  // Number of memory response beats that make up one cache line.
  function automatic int calc_beats(input int line_bytes, input int beat_bits);
    return (line_bytes * 8) / beat_bits;
  endfunction

  // True when v is a power of two and at least 1.
  function automatic bit is_pow2(input int v);
    return (v >= 1) && ((v & (v - 1)) == 0);
  endfunction

  // Beat counter width: clog2(beats), but never narrower than one bit so a
  // single-beat line still has a (constant-zero) counter.
  function automatic int calc_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage : vx_fill_assembler_pkg

// File: rtl/vx_fill_assembler_if.sv
// ---------------------------------------------------------------------------
// vx_fill_assembler_if
//
// Bundles the two handshakes around the fill assembler:
//   memory response side : mem_rsp_valid, mem_rsp_data, mem_rsp_addr -> in
//                          mem_rsp_ready                              <- out
//   fill side            : fill_valid, fill_addr, fill_data           <- out
//                          fill_ready                                 -> in
//   status               : addr_err (one-cycle pulse)                 <- out
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// exactly when valid && ready are both high in the cycle before that edge.
// A producer holds its payload stable while valid is high and ready is low;
// ready may depend combinationally on the consumer's own inputs.
//
// Modports:
//   master : the environment (memory response source + fill consumer)
//   slave  : the assembler
// ---------------------------------------------------------------------------
interface vx_fill_assembler_if #(
  parameter int CACHE_LINE_SIZE = 64,
  parameter int MEM_DATA_WIDTH  = 128,
  parameter int LINE_ADDR_WIDTH = 26
);

  logic                         mem_rsp_valid;
  logic [MEM_DATA_WIDTH-1:0]    mem_rsp_data;
  logic [LINE_ADDR_WIDTH-1:0]   mem_rsp_addr;
  logic                         mem_rsp_ready;

  logic                         fill_valid;
  logic [LINE_ADDR_WIDTH-1:0]   fill_addr;
  logic [CACHE_LINE_SIZE*8-1:0] fill_data;
  logic                         fill_ready;

  logic                         addr_err;

  modport master (
    output mem_rsp_valid,
    output mem_rsp_data,
    output mem_rsp_addr,
    input  mem_rsp_ready,
    input  fill_valid,
    input  fill_addr,
    input  fill_data,
    output fill_ready,
    input  addr_err
  );

  modport slave (
    input  mem_rsp_valid,
    input  mem_rsp_data,
    input  mem_rsp_addr,
    output mem_rsp_ready,
    output fill_valid,
    output fill_addr,
    output fill_data,
    input  fill_ready,
    output addr_err
  );

endinterface : vx_fill_assembler_if

// File: rtl/vx_fill_assembler.sv
// ---------------------------------------------------------------------------
// vx_fill_assembler
//
// Gathers BEATS consecutive memory response beats into one cache line and
// offers the assembled line on the data-access fill port.
//
// Ports:
//   clk        : single clock, all state changes on its rising edge
//   reset      : asynchronous active-high reset; discards any partial line
//   bus        : vx_fill_assembler_if.slave
//                  mem_rsp_valid/data/addr in, mem_rsp_ready out
//                  fill_valid/addr/data out, fill_ready in
//                  addr_err out (one-cycle pulse on beat address mismatch)
//   state_dbg  : current assembler state (IDLE / COLLECT / FULL)
//
// Behaviour:
//   - The first beat of a line latches its address into fill_addr and is
//     stored as beat 0; beat k lands in fill_data[k*MEM_DATA_WIDTH +: ...].
//   - After beat BEATS-1 the line is FULL and fill_valid is high from the
//     next cycle on, until the fill port consumes it.
//   - While FULL the response side is only ready when the fill side is
//     ready, so the beat accepted on the consuming cycle starts the next
//     line with no bubble.
//   - A beat whose address differs from the latched line address is still
//     stored (the latched address is kept) and raises addr_err for a cycle.
// ---------------------------------------------------------------------------
module vx_fill_assembler
  import vx_fill_assembler_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = DEFAULT_CACHE_LINE_SIZE,
  parameter int MEM_DATA_WIDTH  = DEFAULT_MEM_DATA_WIDTH,
  parameter int LINE_ADDR_WIDTH = DEFAULT_LINE_ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  vx_fill_assembler_if.slave  bus,
  output fill_state_e         state_dbg
);

  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam int BEATS  = calc_beats(CACHE_LINE_SIZE, MEM_DATA_WIDTH);
  localparam int CNT_W  = calc_cnt_width(BEATS);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  // Geometry guard: a line must split into a power-of-two number of whole
  // beats, otherwise the beat counter wrap and the slot layout break.
  generate
    if (!is_pow2(BEATS) || ((LINE_W % MEM_DATA_WIDTH) != 0)) begin : g_bad_geometry
      $error("vx_fill_assembler: CACHE_LINE_SIZE*8/MEM_DATA_WIDTH must be a power of two >= 1");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  fill_state_e                state;
  logic [CNT_W-1:0]           beat_cnt;
  logic                       fill_valid_q;
  logic                       addr_err_q;
  logic [LINE_ADDR_WIDTH-1:0] fill_addr_q;
  logic [LINE_W-1:0]          line_q;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic accept;       // a response beat transfers this cycle
  logic last_beat;    // the beat being accepted completes the line
  logic starts_line;  // the beat being accepted is beat 0 of a new line
  logic addr_mismatch;

  // Ready only drops while a full line is waiting on a stalled fill port.
  // Reset forces IDLE asynchronously, so ready is 1 throughout reset.
  assign bus.mem_rsp_ready = (state != FULL) || bus.fill_ready;

  assign accept        = bus.mem_rsp_valid && bus.mem_rsp_ready;
  assign last_beat     = (beat_cnt == LAST_IDX);
  // Outside COLLECT the counter is always 0, so any accepted beat there
  // (IDLE, or FULL while the line is being consumed) opens a new line.
  assign starts_line   = accept && (state != COLLECT);
  assign addr_mismatch = (bus.mem_rsp_addr != fill_addr_q);

  // -------------------------------------------------------------------------
  // FSM, beat counter and registered status outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      fill_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      addr_err_q <= accept && (state == COLLECT) && addr_mismatch;

      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state        <= last_beat ? FULL : COLLECT;
            fill_valid_q <= last_beat;
          end
        end

        COLLECT: begin
          if (accept && last_beat) begin
            state        <= FULL;
            fill_valid_q <= 1'b1;
          end
        end

        FULL: begin
          if (bus.fill_ready) begin
            if (accept) begin
              // Line consumed and the next line's beat 0 taken together.
              state        <= last_beat ? FULL : COLLECT;
              fill_valid_q <= last_beat;
            end else begin
              state        <= IDLE;
              fill_valid_q <= 1'b0;
            end
          end
        end

        default: begin
          state        <= IDLE;
          fill_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Line datapath (no reset: contents are only meaningful while FULL)
  // -------------------------------------------------------------------------
  // Nothing is accepted while FULL and stalled, so address and data hold
  // still for as long as the fill port keeps the line waiting.
  always_ff @(posedge clk) begin
    if (starts_line) begin
      fill_addr_q <= bus.mem_rsp_addr;
    end
    for (int k = 0; k < BEATS; k++) begin
      if (accept && (beat_cnt == CNT_W'(k))) begin
        line_q[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= bus.mem_rsp_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_addr  = fill_addr_q;
  assign bus.fill_data  = line_q;
  assign bus.addr_err   = addr_err_q;
  assign state_dbg      = state;

endmodule : vx_fill_assembler
